ap_ctrl_perf_monitor: RTL

AP_CTRL_PERF_MONITOR -- requirements
Module: ap_ctrl_perf_monitor

---
 rtl/ap_ctrl_perf_pkg.sv | 32 +++
 rtl/ap_ctrl_chan_stat.sv | 155 +++++++++++++++
 rtl/ap_ctrl_perf_monitor.sv | 108 ++++++++++
 3 files changed

// File: rtl/ap_ctrl_perf_pkg.sv
// ap_ctrl_perf_pkg
//   Shared types for the ap_ctrl performance monitor: per-channel FSM state
//   enum, readout field encodings and the per-channel statistics record.
//   Statistics fields are carried at STAT_W bits; channels zero-extend their
//   CNT_W counters into the record and the readout mux truncates back.
package ap_ctrl_perf_pkg;

    localparam int STAT_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } chan_state_e;

    localparam logic [2:0] RD_STARTS   = 3'd0;
    localparam logic [2:0] RD_DONES    = 3'd1;
    localparam logic [2:0] RD_LAST_LAT = 3'd2;
    localparam logic [2:0] RD_MAX_LAT  = 3'd3;
    localparam logic [2:0] RD_MIN_INT  = 3'd4;
    localparam logic [2:0] RD_STALLS   = 3'd5;

    typedef struct packed {
        logic [STAT_W-1:0] starts;
        logic [STAT_W-1:0] dones;
        logic [STAT_W-1:0] last_lat;
        logic [STAT_W-1:0] max_lat;
        logic [STAT_W-1:0] min_int;
        logic [STAT_W-1:0] stalls;
    } chan_stat_t;

endpackage

// File: rtl/ap_ctrl_chan_stat.sv
// ap_ctrl_chan_stat
//   One monitored ap_ctrl channel: IDLE/BUSY/HOLD tracker plus saturating
//   statistics (starts, dones, last/max latency, min ready interval, stalls).
//   Optional watchdog under AP_CTRL_PERF_MON_WDOG_EN.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   hold                - freeze statistics (FSM keeps tracking the handshake)
//   ap_start/ap_ready/ap_done/ap_continue - handshake taps for this channel
//   busy                - transaction in flight (BUSY or HOLD)
//   stat                - statistics record, zero-extended to STAT_W
//   wdog_limit/wdog_trip - watchdog limit and sticky trip (macro only)
module ap_ctrl_chan_stat
    import ap_ctrl_perf_pkg::*;
#(
    parameter int CNT_W = 32
`ifdef AP_CTRL_PERF_MON_WDOG_EN
   ,parameter int WDOG_W = 16
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_continue,
`ifdef AP_CTRL_PERF_MON_WDOG_EN
    input  logic [WDOG_W-1:0] wdog_limit,
    output logic              wdog_trip,
`endif
    output logic              busy,
    output chan_stat_t        stat
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    chan_state_e      state, state_n;
    logic             cnt_start, cnt_done;
    logic [CNT_W-1:0] lat, lat_inc, done_lat;
    logic [CNT_W-1:0] starts, dones, last_lat, max_lat, min_int, stalls;
    logic [CNT_W-1:0] int_cnt, ready_gap;
    logic             armed;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cnt_start = 1'b0;
        cnt_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ap_start) begin
                    cnt_start = 1'b1;
                    if (ap_done) begin
                        // start and done together: zero-latency transaction
                        cnt_done = 1'b1;
                        state_n  = ap_continue ? ST_IDLE : ST_HOLD;
                    end else begin
                        state_n = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (ap_done) begin
                    cnt_done = 1'b1;
                    if (!ap_continue)  state_n = ST_HOLD;
                    else if (ap_start) begin
                        cnt_start = 1'b1;
                        state_n   = ST_BUSY;
                    end else           state_n = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // a start seen here is not a new transaction
                if (ap_continue) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy     = (state != ST_IDLE);
    // latency includes the done cycle itself; IDLE start+done reports 0
    assign lat_inc  = sat_inc(lat);
    assign done_lat = (state == ST_BUSY) ? lat_inc : '0;

    always_ff @(posedge clock) begin
        if (reset)                 lat <= '0;
        else if (cnt_start)        lat <= '0;
        else if (state == ST_BUSY) lat <= lat_inc;
    end

    // cycles since the previous ready pulse; gap is measured edge to edge
    assign ready_gap = sat_inc(int_cnt);

    always_ff @(posedge clock) begin
        if (reset || ap_ready) int_cnt <= '0;
        else                   int_cnt <= ready_gap;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starts   <= '0;
            dones    <= '0;
            last_lat <= '0;
            max_lat  <= '0;
            min_int  <= '1;
            stalls   <= '0;
            armed    <= 1'b0;
        end else if (!hold) begin
            if (cnt_start) starts <= sat_inc(starts);
            if (cnt_done) begin
                dones    <= sat_inc(dones);
                last_lat <= done_lat;
                if (done_lat > max_lat) max_lat <= done_lat;
            end
            if (state == ST_HOLD) stalls <= sat_inc(stalls);
            if (ap_ready) begin
                armed <= 1'b1;
                if (armed && (ready_gap < min_int)) min_int <= ready_gap;
            end
        end
    end

    assign stat.starts   = STAT_W'(starts);
    assign stat.dones    = STAT_W'(dones);
    assign stat.last_lat = STAT_W'(last_lat);
    assign stat.max_lat  = STAT_W'(max_lat);
    assign stat.min_int  = STAT_W'(min_int);
    assign stat.stalls   = STAT_W'(stalls);

`ifdef AP_CTRL_PERF_MON_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt, wdog_inc;

    // consecutive cycles out of IDLE, including the current one
    assign wdog_inc = (&wdog_cnt) ? wdog_cnt : wdog_cnt + WDOG_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            wdog_cnt  <= '0;
            wdog_trip <= 1'b0;
        end else if (state == ST_IDLE) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_inc;
            if (wdog_inc > wdog_limit) wdog_trip <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor
//   Passive performance monitor for N_CH ap_ctrl handshake channels.
//   Holds the finish/frozen latch and the registered readout mux; the
//   per-channel tracking lives in ap_ctrl_chan_stat.
//   Optional watchdog: define AP_CTRL_PERF_MON_WDOG_EN to add wdog_limit
//   and wdog_trip.
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   finish         - end of run; sets frozen and holds all statistics
//   ap_start/ap_ready/ap_done/ap_continue [N_CH] - handshake taps
//   rd_ch, rd_sel  - readout channel / field select
//   rd_data        - registered readout (1-cycle latency, 0 when out of range)
//   frozen         - finish has been seen since reset
//   busy [N_CH]    - per-channel transaction in flight
//   wdog_limit, wdog_trip [N_CH] - watchdog (macro only)
module ap_ctrl_perf_monitor
    import ap_ctrl_perf_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 32,
    parameter int WDOG_W = 16
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    finish,
    input  logic [N_CH-1:0]                         ap_start,
    input  logic [N_CH-1:0]                         ap_ready,
    input  logic [N_CH-1:0]                         ap_done,
    input  logic [N_CH-1:0]                         ap_continue,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] rd_ch,
    input  logic [2:0]                              rd_sel,
`ifdef AP_CTRL_PERF_MON_WDOG_EN
    input  logic [WDOG_W-1:0]                       wdog_limit,
    output logic [N_CH-1:0]                         wdog_trip,
`endif
    output logic [CNT_W-1:0]                        rd_data,
    output logic                                    frozen,
    output logic [N_CH-1:0]                         busy
);

    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    // pad to a power of two so rd_ch always indexes a valid slot
    localparam int N_SLOT = 1 << CH_W;

`ifndef AP_CTRL_PERF_MON_WDOG_EN
    localparam int unused_wdog_w = WDOG_W;
`endif

    chan_stat_t        stats [N_SLOT];
    chan_stat_t        sel_stat;
    logic [STAT_W-1:0] rd_next;
    logic              unused_rd_hi;

    always_ff @(posedge clock) begin
        if (reset)       frozen <= 1'b0;
        else if (finish) frozen <= 1'b1;
    end

    for (genvar g = 0; g < N_SLOT; g++) begin : g_ch
        if (g < N_CH) begin : g_live
            ap_ctrl_chan_stat #(
                .CNT_W (CNT_W)
`ifdef AP_CTRL_PERF_MON_WDOG_EN
               ,.WDOG_W(WDOG_W)
`endif
            ) u_chan (
                .clock       (clock),
                .reset       (reset),
                .hold        (frozen),
                .ap_start    (ap_start[g]),
                .ap_ready    (ap_ready[g]),
                .ap_done     (ap_done[g]),
                .ap_continue (ap_continue[g]),
`ifdef AP_CTRL_PERF_MON_WDOG_EN
                .wdog_limit  (wdog_limit),
                .wdog_trip   (wdog_trip[g]),
`endif
                .busy        (busy[g]),
                .stat        (stats[g])
            );
        end else begin : g_pad
            assign stats[g] = '0;
        end
    end

    always_comb begin
        sel_stat = stats[rd_ch];
        rd_next  = '0;
        case (rd_sel)
            RD_STARTS:   rd_next = sel_stat.starts;
            RD_DONES:    rd_next = sel_stat.dones;
            RD_LAST_LAT: rd_next = sel_stat.last_lat;
            RD_MAX_LAT:  rd_next = sel_stat.max_lat;
            RD_MIN_INT:  rd_next = sel_stat.min_int;
            RD_STALLS:   rd_next = sel_stat.stalls;
            default:     rd_next = '0;
        endcase
    end

    // bits above CNT_W are always zero
    assign unused_rd_hi = ^rd_next;

    always_ff @(posedge clock) begin
        if (reset) rd_data <= '0;
        else       rd_data <= rd_next[CNT_W-1:0];
    end

endmodule
